// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
  localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: two requester ports plus the data-memory side of the arbiter.
interface dmem_arbiter_if;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic        m0_ack_o, m1_ack_o, err_o, busy_o, mem_we_o, mem_re_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, mem_rdata_i,
    output m0_ack_o, m1_ack_o, rdata_o, err_o, busy_o,
    output mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
  );
  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, mem_rdata_i,
    input  m0_ack_o, m1_ack_o, rdata_o, err_o, busy_o,
    input  mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
  );
endinterface

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin pick; on a tie the master not granted last wins.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);
  always_comb begin
    grant_valid = |req;
    grant_idx = &req ? ~last_grant : req[1];
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of a single-port data memory between M0 and M1.
// Defining DMEM_RANGE_CHECK_EN rejects misaligned/out-of-range grants with err_o.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int MEM_BYTES = 32
) (
  input logic clk_i,
  input logic rst_i,
  dmem_arbiter_if.slave bus
);
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  state_t state, next;
  logic last_grant, idx, we_q, err_q, gv, gi, g_we, bad;
  logic [31:0] addr_q, wdata_q, rdata_q, g_addr, g_wdata;
  logic [CNT_W-1:0] cnt;
  rr_arbiter_2 u_rr (
    .req({bus.m1_req_i, bus.m0_req_i}),
    .last_grant(last_grant),
    .grant_valid(gv),
    .grant_idx(gi)
  );
  always_comb begin
    g_we = gi ? bus.m1_we_i : bus.m0_we_i;
    g_addr = gi ? bus.m1_addr_i : bus.m0_addr_i;
    g_wdata = gi ? bus.m1_wdata_i : bus.m0_wdata_i;
    bad = CHK && (g_addr[1:0] != 2'b00 || g_addr > 32'(MEM_BYTES - 4));
    next = state == IDLE ? (gv ? (bad ? RESP : ACCESS) : IDLE) :
           state == ACCESS ? (cnt == '0 ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      last_grant <= M1;
      idx <= M0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt <= '0;
    end else begin
      state <= next;
      if (state == IDLE && gv) begin
        idx <= gi;
        last_grant <= gi;
        we_q <= g_we;
        err_q <= bad;
        addr_q <= g_addr;
        wdata_q <= g_wdata;
        rdata_q <= '0;
        cnt <= CNT_W'(WAIT_CYCLES);
      end else if (state == ACCESS) begin
        cnt <= cnt == '0 ? cnt : cnt - 1'b1;
        if (cnt == '0 && !we_q) rdata_q <= bus.mem_rdata_i;
      end
    end
  end
  always_comb begin
    bus.m0_ack_o = state == RESP && idx == M0;
    bus.m1_ack_o = state == RESP && idx == M1;
    bus.rdata_o = rdata_q;
    bus.err_o = err_q;
    bus.busy_o = state != IDLE;
    bus.mem_addr_o = addr_q;
    bus.mem_wdata_o = wdata_q;
    bus.mem_re_o = state == ACCESS && !we_q;
    bus.mem_we_o = state == ACCESS && we_q && cnt == '0;
  end
endmodule
